// File: rtl/graph_pkg.sv
// graph_pkg: shared sizing and FSM encoding for the graph bank controller.
// No ports; imported by graph_dp_ram and graph_bank_ctrl.
package graph_pkg;

  localparam int GRAPH_NUM_BINS = 200;
  localparam int GRAPH_DATA_W   = 9;
  localparam int GRAPH_ADDR_W   = 8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FULL = 2'd1,
    ST_SWAP = 2'd2
  } graph_state_e;

endpackage

// File: rtl/graph_dp_ram.sv
// graph_dp_ram: simple dual-port RAM, one write port, one registered read.
// Ports: clk, we/waddr/wdata (write), raddr -> rdata (1-cycle latency).
module graph_dp_ram
  import graph_pkg::*;
#(
  parameter int DEPTH  = GRAPH_NUM_BINS,
  parameter int ADDR_W = GRAPH_ADDR_W,
  parameter int DATA_W = GRAPH_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/graph_bank_ctrl.sv
// graph_bank_ctrl: double-buffered bar-graph store, swapped at vblank.
// Ports: clk_25m, rst_n, wr_valid/wr_ready/wr_data/wr_last (producer),
// vblank_start, rd_addr -> rd_data (renderer), swapped, short_frame,
// miss_cnt. Macro GRAPH_MISS_CNT_EN enables the saturating miss counter.
module graph_bank_ctrl
  import graph_pkg::*;
#(
  parameter int NUM_BINS = GRAPH_NUM_BINS,
  parameter int ADDR_W   = GRAPH_ADDR_W,
  parameter int DATA_W   = GRAPH_DATA_W
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              vblank_start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              swapped,
  output logic              short_frame,
  output logic [15:0]       miss_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

  graph_state_e      state, state_nxt;
  logic              disp_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic              xfer, at_end, done, miss;
  logic              we0, we1;
  logic              sel_q, oob_q;
  logic [DATA_W-1:0] q0, q1;

  assign xfer   = wr_valid && wr_ready;
  assign at_end = (wr_addr == LAST_ADDR);
  assign done   = xfer && (wr_last || at_end);
  assign miss   = (state == ST_FILL) && vblank_start;

  // disp_sel names the display bank; the other one is written.
  assign we0 = xfer && disp_sel;
  assign we1 = xfer && !disp_sel;

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) state <= ST_FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FILL: if (done)         state_nxt = ST_FULL;
      ST_FULL: if (vblank_start) state_nxt = ST_SWAP;
      ST_SWAP:                   state_nxt = ST_FILL;
      default:                   state_nxt = ST_FILL;
    endcase
  end

  always_comb begin
    wr_ready = (state == ST_FILL);
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      disp_sel    <= 1'b0;
      wr_addr     <= '0;
      swapped     <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      swapped <= (state == ST_SWAP);
      if (state == ST_SWAP) begin
        disp_sel <= ~disp_sel;
        wr_addr  <= '0;
      end else if (xfer) begin
        wr_addr <= wr_addr + 1'b1;
      end
      if (xfer && wr_last && !at_end) short_frame <= 1'b1;
    end
  end

  // Bank select and range flag are captured with the address so the
  // registered read reflects the bank that was live when it was issued.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 1'b0;
      oob_q <= 1'b1;
    end else begin
      sel_q <= disp_sel;
      oob_q <= (32'(rd_addr) >= 32'(NUM_BINS));
    end
  end

  assign rd_data = oob_q ? '0 : (sel_q ? q1 : q0);

`ifdef GRAPH_MISS_CNT_EN
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n)                       miss_cnt <= '0;
    else if (miss && miss_cnt != '1)  miss_cnt <= miss_cnt + 16'd1;
  end
`else
  assign miss_cnt = '0;
  logic unused_miss;
  assign unused_miss = miss;
`endif

  graph_dp_ram #(
    .DEPTH (NUM_BINS),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_bank0 (
    .clk  (clk_25m),
    .we   (we0),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(q0)
  );

  graph_dp_ram #(
    .DEPTH (NUM_BINS),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_bank1 (
    .clk  (clk_25m),
    .we   (we1),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(q1)
  );

endmodule

// File: tb/tb_graph_bank_ctrl.sv
// tb_graph_bank_ctrl: directed self-checking bench for graph_bank_ctrl.
// Scenario tasks run in sequence; one summary line at the end.
module tb_graph_bank_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 9;
`ifdef GRAPH_MISS_CNT_EN
  localparam int MISS_EXP = 1;
`else
  localparam int MISS_EXP = 0;
`endif

  logic              clk_25m = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_last = 1'b0;
  logic              vblank_start = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              swapped;
  logic              short_frame;
  logic [15:0]       miss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  graph_bank_ctrl dut (
    .clk_25m     (clk_25m),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .vblank_start(vblank_start),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .swapped     (swapped),
    .short_frame (short_frame),
    .miss_cnt    (miss_cnt)
  );

  always #20 clk_25m = ~clk_25m;

  task automatic tick();
    @(posedge clk_25m);
    #1;
  endtask

  task automatic write_frame(input int n, input int base, input bit lst);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = DATA_W'(base + i);
      wr_last  = lst && (i == n - 1);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic read_bin(input int a, output logic [DATA_W-1:0] v);
    rd_addr = ADDR_W'(a);
    tick();
    v = rd_data;
  endtask

  task automatic do_swap(output int seen);
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    seen = 0;
    repeat (3) begin
      if (swapped === 1'b1) seen++;
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++;
    if (rd_data !== '0) begin
      n_bad++; $display("FAIL reset_rd_data: got %0d want 0", rd_data);
    end
    n_cmp++;
    if (swapped !== 1'b0 || short_frame !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b%b want 00", swapped, short_frame);
    end
    n_cmp++;
    if (miss_cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_miss: got %0d want 0", miss_cnt);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", wr_ready);
    end
  endtask

  task automatic test_full_frame();
    logic [DATA_W-1:0] v;
    int seen;
    write_frame(200, 0, 1'b1);
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_bad++; $display("FAIL full_ready: got %b want 0", wr_ready);
    end
    do_swap(seen);
    n_cmp++;
    if (seen != 1) begin
      n_bad++; $display("FAIL full_swapped: got %0d pulses want 1", seen);
    end
    read_bin(37, v);
    n_cmp++;
    if (v !== 9'd37) begin
      n_bad++; $display("FAIL full_bin37: got %0d want 37", v);
    end
    read_bin(199, v);
    n_cmp++;
    if (v !== 9'd199) begin
      n_bad++; $display("FAIL full_bin199: got %0d want 199", v);
    end
    read_bin(200, v);
    n_cmp++;
    if (v !== 9'd0) begin
      n_bad++; $display("FAIL oob_200: got %0d want 0", v);
    end
    read_bin(255, v);
    n_cmp++;
    if (v !== 9'd0) begin
      n_bad++; $display("FAIL oob_255: got %0d want 0", v);
    end
    n_cmp++;
    if (short_frame !== 1'b0) begin
      n_bad++; $display("FAIL full_short: got %b want 0", short_frame);
    end
  endtask

  task automatic test_short_frame();
    logic [DATA_W-1:0] v;
    int seen;
    write_frame(200, 0, 1'b0);
    write_frame(0, 0, 1'b0);
    wr_valid = 1'b0;
    do_swap(seen);
    // previous call wrote 0..199 with no last; bin 199 closes the frame
    read_bin(10, v);
    n_cmp++;
    if (v !== 9'd10) begin
      n_bad++; $display("FAIL pre_short_bin10: got %0d want 10", v);
    end
    write_frame(10, 300, 1'b1);
    n_cmp++;
    if (short_frame !== 1'b1) begin
      n_bad++; $display("FAIL short_flag: got %b want 1", short_frame);
    end
    do_swap(seen);
    n_cmp++;
    if (seen != 1) begin
      n_bad++; $display("FAIL short_swapped: got %0d pulses want 1", seen);
    end
    read_bin(0, v);
    n_cmp++;
    if (v !== 9'd300) begin
      n_bad++; $display("FAIL short_bin0: got %0d want 300", v);
    end
    read_bin(9, v);
    n_cmp++;
    if (v !== 9'd309) begin
      n_bad++; $display("FAIL short_bin9: got %0d want 309", v);
    end
    read_bin(10, v);
    n_cmp++;
    if (v !== 9'd10) begin
      n_bad++; $display("FAIL short_bin10: got %0d want 10", v);
    end
  endtask

  task automatic test_miss();
    logic [DATA_W-1:0] v;
    int seen;
    write_frame(50, 250, 1'b0);
    do_swap(seen);
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL miss_swapped: got %0d pulses want 0", seen);
    end
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_bad++; $display("FAIL miss_ready: got %b want 1", wr_ready);
    end
    n_cmp++;
    if (miss_cnt !== 16'(MISS_EXP)) begin
      n_bad++;
      $display("FAIL miss_cnt: got %0d want %0d", miss_cnt, MISS_EXP);
    end
    read_bin(0, v);
    n_cmp++;
    if (v !== 9'd300) begin
      n_bad++; $display("FAIL miss_display: got %0d want 300", v);
    end
    write_frame(150, 300, 1'b1);
    do_swap(seen);
    n_cmp++;
    if (seen != 1) begin
      n_bad++; $display("FAIL miss_late_swap: got %0d pulses want 1", seen);
    end
    read_bin(0, v);
    n_cmp++;
    if (v !== 9'd250) begin
      n_bad++; $display("FAIL miss_bin0: got %0d want 250", v);
    end
    read_bin(120, v);
    n_cmp++;
    if (v !== 9'd370) begin
      n_bad++; $display("FAIL miss_bin120: got %0d want 370", v);
    end
  endtask

  task automatic test_coincident();
    logic [DATA_W-1:0] v;
    int seen;
    int early;
    write_frame(199, 7, 1'b0);
    for (int i = 0; i < 0; i++) tick();
    wr_valid     = 1'b1;
    wr_data      = 9'd77;
    wr_last      = 1'b1;
    vblank_start = 1'b1;
    tick();
    wr_valid     = 1'b0;
    wr_last      = 1'b0;
    vblank_start = 1'b0;
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_bad++; $display("FAIL coin_ready: got %b want 0", wr_ready);
    end
    early = 0;
    repeat (3) begin
      if (swapped === 1'b1) early++;
      tick();
    end
    n_cmp++;
    if (early != 0 || wr_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL coin_hold: got %0d pulses ready %b want 0 0",
               early, wr_ready);
    end
    read_bin(0, v);
    n_cmp++;
    if (v !== 9'd250) begin
      n_bad++; $display("FAIL coin_old_bank: got %0d want 250", v);
    end
    do_swap(seen);
    n_cmp++;
    if (seen != 1) begin
      n_bad++; $display("FAIL coin_swapped: got %0d pulses want 1", seen);
    end
    read_bin(199, v);
    n_cmp++;
    if (v !== 9'd77) begin
      n_bad++; $display("FAIL coin_bin199: got %0d want 77", v);
    end
    read_bin(198, v);
    n_cmp++;
    if (v !== 9'd205) begin
      n_bad++; $display("FAIL coin_bin198: got %0d want 205", v);
    end
  endtask

  function automatic logic [DATA_W-1:0] b2b_val(input int k);
    return (k < 200) ? DATA_W'(20 + k) : DATA_W'(300 + (k - 200) % 200);
  endfunction

  task automatic test_back_to_back();
    logic [DATA_W-1:0] v;
    int  k = 0;
    int  bad = 0;
    int  cyc = 0;
    bit  acc;
    wr_valid = 1'b1;
    for (int f = 0; f < 2; f++) begin
      while (k < (f + 1) * 200 && cyc < 2000) begin
        wr_data = b2b_val(k);
        wr_last = (k % 200) == 199;
        acc = wr_ready;
        tick();
        cyc++;
        if (acc) k++;
      end
      wr_data = b2b_val(k);
      wr_last = 1'b0;
      repeat (2) begin
        acc = wr_ready;
        if (acc) bad++;
        tick();
        if (acc) k++;
      end
      vblank_start = 1'b1;
      acc = wr_ready;
      if (acc) bad++;
      tick();
      vblank_start = 1'b0;
      if (acc) k++;
      if (wr_ready !== 1'b0) bad++;
    end
    wr_valid = 1'b0;
    tick();
    n_cmp++;
    if (k != 400) begin
      n_bad++; $display("FAIL b2b_beats: got %0d want 400", k);
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL b2b_ready_low: got %0d bad want 0", bad);
    end
    read_bin(0, v);
    n_cmp++;
    if (v !== 9'd300) begin
      n_bad++; $display("FAIL b2b_bin0: got %0d want 300", v);
    end
    read_bin(57, v);
    n_cmp++;
    if (v !== 9'd357) begin
      n_bad++; $display("FAIL b2b_bin57: got %0d want 357", v);
    end
    read_bin(199, v);
    n_cmp++;
    if (v !== 9'd499) begin
      n_bad++; $display("FAIL b2b_bin199: got %0d want 499", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] v;
    int seen;
    write_frame(120, 5, 1'b0);
    wr_valid = 1'b1;
    wr_data  = 9'd111;
    rst_n    = 1'b0;
    #1;
    n_cmp++;
    if (rd_data !== '0 || swapped !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_out: got %0d %b want 0 0", rd_data, swapped);
    end
    n_cmp++;
    if (short_frame !== 1'b0 || miss_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_mid_flags: got %b %0d want 0 0",
               short_frame, miss_cnt);
    end
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_ready: got %b want 1", wr_ready);
    end
    wr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    write_frame(200, 60, 1'b1);
    do_swap(seen);
    n_cmp++;
    if (seen != 1) begin
      n_bad++; $display("FAIL rst_mid_swap: got %0d pulses want 1", seen);
    end
    read_bin(0, v);
    n_cmp++;
    if (v !== 9'd60) begin
      n_bad++; $display("FAIL rst_mid_bin0: got %0d want 60", v);
    end
    read_bin(119, v);
    n_cmp++;
    if (v !== 9'd179) begin
      n_bad++; $display("FAIL rst_mid_bin119: got %0d want 179", v);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_miss();
    test_coincident();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
